snes_pad_encoder: RTL and testbench
===================================

Name: snes_pad_encoder

Overview:
Parametrised controller-side SNES pad emulator that replaces the fixed-width encoder.
- Merges NUM_SRC active-high button vectors (PS/2 keyboard, IR, push buttons, ...) using a selectable mode.
- Snapshots the merged vector on the console latch and shifts it out serially, active-low, on the console clock.
- Synchronises both async console strobes, pads frames beyond BTN_W, and recovers from stalled frames with a timeout.

Parameters:
- NUM_SRC, 3: number of input sources.
- BTN_W, 12: buttons per source; bit 0 = B, Y, Select, Start, Up, Down, Left, Right, A, X, L, bit 11 = R.
- FRAME_BITS, 16: serial bits per frame; must be >= BTN_W.
- SYNC_STAGES, 2: synchroniser depth for snes_latch/snes_clk.
- TIMEOUT_CYC, 1024: idle clk cycles in SHIFT before abort.

Ports:
- clk  in  1  system clock (2.08 MHz internal oscillator).
- reset_n  in  1  asynchronous, active-low reset.
- src_btn  in  NUM_SRC*BTN_W  source s occupies bits [s*BTN_W +: BTN_W]; 1 = pressed.
- src_valid  in  NUM_SRC  1 = source s currently valid.
- mode  in  2  0 = SELECT, 1 = OR_MERGE, 2 = PRIORITY, 3 = reserved.
- sel  in  $clog2(NUM_SRC)  source index used in SELECT mode.
- snes_latch  in  1  console latch; asynchronous.
- snes_clk  in  1  console clock; asynchronous.
- snes_data  out  1  serial data to console; 0 = pressed.
- busy  out  1  high in LATCH or SHIFT.
- frame_done  out  1  one-cycle pulse at normal frame completion.

Behaviour:
- Reset values (asynchronous): snes_data=1, busy=0, frame_done=0, state=IDLE, idx=0, timeout counter=0, synchronisers cleared to 0.
- Synchronisation and edge detect: each strobe passes SYNC_STAGES flops, then a previous-value flop; rise = sync & ~prev.
  - Outputs update on the clk edge where rise is high.
  - Latency: SYNC_STAGES+1 clk edges after the first edge that samples the new pin level.
- Merge, combinational; only consumed at the latch snapshot:
  - SELECT: src[sel] if src_valid[sel], else 0. sel >= NUM_SRC gives 0.
  - OR_MERGE: bitwise OR of all valid sources.
  - PRIORITY: lowest-index valid source; 0 if none valid.
  - Reserved mode 3: 0.
- Shift register: FRAME_BITS wide. Snapshot = {pad ones, ~merged}, so bits BTN_W..FRAME_BITS-1 shift out as 1 (released).
- State machine:
  - IDLE: snes_data=1.
    - latch rise → LATCH: snapshot, idx=0, snes_data=~merged[0].
  - LATCH: holds bit 0; clk rises are ignored.
    - latch fall → SHIFT.
  - SHIFT: on clk rise, idx++ and present bit idx.
    - When idx reaches FRAME_BITS: snes_data=0, frame_done=1 for one cycle → DONE.
  - DONE: snes_data=0.
    - latch rise → LATCH.
- Timeout: in SHIFT, a counter increments every cycle and clears on each clk rise.
  - At TIMEOUT_CYC: → IDLE, snes_data=1, no frame_done.
- Latch rise in any state restarts the frame with a new snapshot and idx=0.
- Simultaneous latch rise and clk rise in the same cycle: latch wins; the clk rise is dropped.
- mode, sel, src_btn and src_valid changes after the snapshot have no effect until the next latch rise.
- reset_n assertion mid-frame aborts immediately to the reset values.

Decomposition:
- snes_pkg holds:
  - mode_e enum (SELECT, OR_MERGE, PRIORITY, RSVD);
  - state_e enum (IDLE, LATCH, SHIFT, DONE);
  - button bit-index constants (BTN_B=0 ... BTN_R=11);
  - SNES_FRAME_BITS=16.
- Sub-module snes_sync_edge: SYNC_STAGES synchroniser plus rising/falling edge pulses, parametrised by depth, instanced twice.

Test Plan (NUM_SRC=3, BTN_W=12, FRAME_BITS=16):
1. reset_n low with strobes toggling → snes_data=1, busy=0, frame_done=0 throughout; after release, state stays IDLE until the first latch rise.
2. mode=0, sel=1, src1=12'h001 valid; latch, then 16 clk pulses → data bits 0,1,1,…,1 (16 bits); after the 16th rise snes_data=0 and frame_done pulses exactly once.
3. mode=1; src0=12'h0F0 valid, src1=12'hF00 invalid, src2=12'h00F valid → bits 0–7 read 0, bits 8–15 read 1.
4. mode=2; src0 invalid, src1=12'h800 valid, src2=12'h001 valid → only bit 11 reads 0. With all sources invalid → all 16 bits read 1.
5. Latch after 5 clocks with src changed to 12'h002 → restart at bit 0 with new data (bit 1 reads 0). frame_done fires only after 16 further clocks. Latch rise and clk rise arriving in the same sampled cycle → no index advance.
6. Latch, 3 clocks, then no clk for 1024 cycles → snes_data=1, busy=0, no frame_done. Separately, a mode/sel change mid-frame leaves the shifted data unchanged.

Source files
------------

// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES pad encoder.
// Button numbering follows the order in which the console shifts the bits in.
package snes_pkg;

  typedef enum logic [1:0] {
    SELECT   = 2'd0,
    OR_MERGE = 2'd1,
    PRIORITY = 2'd2,
    RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int SNES_FRAME_BITS = 16;

endpackage

// File: rtl/snes_sync_edge.sv
// Multi-stage synchroniser for an asynchronous console strobe.
// Produces one-cycle rising and falling edge pulses in the clk domain.
module snes_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;
  logic              level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/snes_pad_encoder.sv
// Controller-side SNES pad emulator: merges several button sources, snapshots
// the result on the console latch and shifts it out active-low on the console clock.
module snes_pad_encoder
  import snes_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int BTN_W       = 12,
  parameter int FRAME_BITS  = SNES_FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*BTN_W-1:0] src_btn,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     snes_latch,
  input  logic                     snes_clk,
  output logic                     snes_data,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int IDX_W = $clog2(FRAME_BITS + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic                  latch_rise;
  logic                  latch_fall;
  logic                  clk_rise;
  logic                  unused_clk_fall;
  logic [BTN_W-1:0]      merged;
  logic [FRAME_BITS-1:0] snap;
  logic [FRAME_BITS-1:0] frame_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [CNT_W-1:0]      cnt_reg;
  state_e                state_reg;

  snes_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (snes_latch),
    .rise    (latch_rise),
    .fall    (latch_fall)
  );

  snes_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (snes_clk),
    .rise    (clk_rise),
    .fall    (unused_clk_fall)
  );

  always_comb begin
    merged = '0;
    case (mode_e'(mode))
      SELECT: begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (sel == SEL_W'(s) && src_valid[s]) merged = src_btn[s*BTN_W +: BTN_W];
        end
      end
      OR_MERGE: begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (src_valid[s]) merged = merged | src_btn[s*BTN_W +: BTN_W];
        end
      end
      PRIORITY: begin
        // Walk downwards so the lowest-index valid source is written last.
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
          if (src_valid[s]) merged = src_btn[s*BTN_W +: BTN_W];
        end
      end
      default: merged = '0;
    endcase
  end

  // Bits beyond the real buttons always read as released.
  for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_snap
    if (gi < BTN_W) begin : g_btn
      assign snap[gi] = ~merged[gi];
    end else begin : g_pad
      assign snap[gi] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      frame_reg  <= '1;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      snes_data  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (latch_rise) begin
        // A latch always wins, including over a coincident clock rise.
        state_reg <= LATCH;
        frame_reg <= snap;
        idx_reg   <= '0;
        cnt_reg   <= '0;
        snes_data <= snap[0];
        busy      <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: snes_data <= 1'b1;
          LATCH: begin
            if (latch_fall) state_reg <= SHIFT;
          end
          SHIFT: begin
            if (clk_rise) begin
              cnt_reg <= '0;
              if (idx_reg == IDX_W'(FRAME_BITS - 1)) begin
                idx_reg    <= IDX_W'(FRAME_BITS);
                snes_data  <= 1'b0;
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state_reg  <= DONE;
              end else begin
                idx_reg   <= idx_reg + 1'b1;
                frame_reg <= {1'b1, frame_reg[FRAME_BITS-1:1]};
                snes_data <= frame_reg[1];
              end
            end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
              state_reg <= IDLE;
              snes_data <= 1'b1;
              busy      <= 1'b0;
              cnt_reg   <= '0;
              idx_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          DONE: snes_data <= 1'b0;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_encoder.sv
// Randomised scoreboard bench for snes_pad_encoder: the driver queues expected
// pin states from a behavioural frame model, a monitor compares on each probe.
module tb_snes_pad_encoder;

  localparam int HOLD = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] src_b [3];
  logic [35:0] src_btn;
  logic [2:0]  src_valid = '0;
  logic [1:0]  mode = '0;
  logic [1:0]  sel = '0;
  logic        snes_latch = 1'b0;
  logic        snes_clk = 1'b0;
  logic        snes_data;
  logic        busy;
  logic        frame_done;

  typedef struct {
    string tag;
    logic  data;
    logic  busy;
  } item_t;

  item_t       exp_q[$];
  logic        probe_req = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic [15:0] fr;

  assign src_btn = {src_b[2], src_b[1], src_b[0]};

  snes_pad_encoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_btn    (src_btn),
    .src_valid  (src_valid),
    .mode       (mode),
    .sel        (sel),
    .snes_latch (snes_latch),
    .snes_clk   (snes_clk),
    .snes_data  (snes_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Monitor: compares the DUT pins against the oldest queued expectation.
  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (probe_req) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty: probe with no expectation queued");
      end else begin
        item_t it;
        it = exp_q.pop_front();
        checks++;
        if (snes_data !== it.data) begin
          failures++;
          $display("FAIL %s data: got %b expected %b", it.tag, snes_data, it.data);
        end
        checks++;
        if (busy !== it.busy) begin
          failures++;
          $display("FAIL %s busy: got %b expected %b", it.tag, busy, it.busy);
        end
        checks++;
        if (frame_done !== 1'b0) begin
          failures++;
          $display("FAIL %s frame_done: got %b expected 0", it.tag, frame_done);
        end
      end
    end
  end

  function automatic logic [11:0] ref_merge(int m, int s, logic [11:0] b [3], logic [2:0] v);
    logic [11:0] r;
    r = '0;
    case (m)
      0: if (s < 3 && v[s]) r = b[s];
      1: for (int i = 0; i < 3; i++) if (v[i]) r |= b[i];
      2: begin
        for (int i = 0; i < 3; i++) begin
          if (v[i]) begin
            r = b[i];
            break;
          end
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Expected serial frame: pressed buttons read 0, padding reads 1.
  function automatic logic [15:0] ref_frame();
    logic [11:0] m;
    logic [15:0] f;
    m = ref_merge(int'(mode), int'(sel), src_b, src_valid);
    for (int i = 0; i < 16; i++) f[i] = (i < 12) ? ~m[i] : 1'b1;
    return f;
  endfunction

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(string tag, logic d, logic b);
    item_t it;
    it.tag = tag; it.data = d; it.busy = b;
    exp_q.push_back(it);
    probe_req = 1'b1;
    cycles(1);
    probe_req = 1'b0;
  endtask

  task automatic check_done(string tag);
    checks++;
    if (done_seen != exp_done) begin
      failures++;
      $display("FAIL %s frame_done_count: got %0d expected %0d", tag, done_seen, exp_done);
    end
  endtask

  task automatic randomize_inputs();
    mode = 2'($urandom_range(0, 3));
    sel  = 2'($urandom_range(0, 3));
    for (int i = 0; i < 3; i++) src_b[i] = 12'($urandom);
    src_valid = 3'($urandom);
  endtask

  task automatic latch_pulse();
    snes_latch = 1'b1; cycles(HOLD);
    snes_latch = 1'b0; cycles(HOLD);
  endtask

  task automatic clk_pulse();
    snes_clk = 1'b1; cycles(HOLD);
    snes_clk = 1'b0; cycles(HOLD);
  endtask

  task automatic shift_bits(string tag, logic [15:0] f, int k0, int k1, int perturb_at);
    for (int k = k0; k <= k1; k++) begin
      clk_pulse();
      if (k == perturb_at) randomize_inputs();
      if (k < 16) probe($sformatf("%s_b%0d", tag, k), f[k], 1'b1);
      else        probe($sformatf("%s_end", tag), 1'b0, 1'b0);
    end
  endtask

  task automatic run_frame(string tag, int nclk, int perturb_at);
    logic [15:0] f;
    f = ref_frame();
    latch_pulse();
    probe($sformatf("%s_b0", tag), f[0], 1'b1);
    shift_bits(tag, f, 1, nclk, perturb_at);
    if (nclk >= 16) exp_done++;
    check_done(tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) src_b[i] = '0;

    // Reset held while strobes toggle, then release and stay idle without a latch.
    cycles(1);
    for (int i = 0; i < 4; i++) begin
      snes_latch = ~snes_latch; snes_clk = ~snes_clk;
      cycles(3);
      probe($sformatf("rst_%0d", i), 1'b1, 1'b0);
    end
    snes_latch = 1'b0; snes_clk = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(HOLD);
    probe("idle_after_rst", 1'b1, 1'b0);
    clk_pulse(); clk_pulse();
    probe("idle_clk_only", 1'b1, 1'b0);
    check_done("idle");

    // SELECT source 1 with only B pressed.
    randomize_inputs();
    mode = 2'd0; sel = 2'd1; src_b[1] = 12'h001; src_valid[1] = 1'b1;
    run_frame("t2_select", 16, -1);

    // OR merge with one invalid source.
    mode = 2'd1; src_b[0] = 12'h0F0; src_b[1] = 12'hF00; src_b[2] = 12'h00F;
    src_valid = 3'b101;
    run_frame("t3_or", 16, -1);

    // PRIORITY: lowest valid index wins; then nothing valid.
    mode = 2'd2; src_b[0] = 12'($urandom); src_b[1] = 12'h800; src_b[2] = 12'h001;
    src_valid = 3'b110;
    run_frame("t4_prio", 16, -1);
    src_valid = 3'b000;
    run_frame("t4_none", 16, -1);

    // Restart mid-frame with new data.
    mode = 2'd0; sel = 2'd1; src_b[1] = 12'h001; src_valid = 3'b010;
    run_frame("t5_part", 5, -1);
    src_b[1] = 12'h002;
    run_frame("t5_restart", 16, -1);

    // Latch and clock rising together: latch wins, index stays at 0.
    randomize_inputs();
    run_frame("t5_pre", 3, -1);
    randomize_inputs();
    fr = ref_frame();
    snes_latch = 1'b1; snes_clk = 1'b1; cycles(HOLD);
    probe("t5_simul_hi", fr[0], 1'b1);
    snes_latch = 1'b0; snes_clk = 1'b0; cycles(HOLD);
    probe("t5_simul_lo", fr[0], 1'b1);
    shift_bits("t5_simul", fr, 1, 16, -1);
    exp_done++;
    check_done("t5_simul");

    // Stalled frame times out back to idle without frame_done.
    randomize_inputs();
    run_frame("t6_stall", 3, -1);
    fr = ref_frame();
    cycles(980);
    probe("t6_before_timeout", dut.snes_data, 1'b1);
    cycles(40);
    probe("t6_timeout", 1'b1, 1'b0);
    check_done("t6_timeout");

    // Input changes mid-frame must not alter the shifted data.
    randomize_inputs();
    run_frame("t6_perturb", 16, 4);

    // Asynchronous reset mid-frame.
    randomize_inputs();
    run_frame("rst_mid", 3, -1);
    reset_n = 1'b0;
    #2;
    checks++;
    if (snes_data !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got data=%b busy=%b expected data=1 busy=0", snes_data, busy);
    end
    cycles(2);
    reset_n = 1'b1;
    cycles(HOLD);
    probe("rst_mid_idle", 1'b1, 1'b0);

    // Random frames.
    for (int n = 0; n < 12; n++) begin
      randomize_inputs();
      run_frame($sformatf("rnd%0d", n), 16, -1);
    end

    cycles(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
